nzp_flag_stack: RTL

Parametrised successor to the single-set condition-code register. It derives N/Z/P from a DATA_W-bit result, and also holds carry and overflow flags. A STACK_DEPTH-entry shadow stack saves and restores the full flag set across interrupt/trap entry and return. It also evaluates branch conditions from the registered flags. Sits between the ALU writeback path and the control unit / branch logic.

---
 rtl/nzp_flag_stack.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/nzp_flag_stack.sv
// Condition-code register with N/Z/P derivation, carry/overflow latching,
// a LIFO shadow stack for trap entry/return, and branch-condition evaluation.
module nzp_flag_stack #(
    parameter int DATA_W      = 16,
    parameter int STACK_DEPTH = 4,
    parameter int PTR_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [DATA_W-1:0] result,
    input  logic              c_in,
    input  logic              v_in,
    input  logic              push,
    input  logic              pop,
    input  logic              err_clr,
    input  logic [2:0]        br_nzp,
    output logic              N,
    output logic              Z,
    output logic              P,
    output logic              C,
    output logic              V,
    output logic              br_taken,
    output logic [PTR_W-1:0]  depth,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err
);

    // Flag-set layout {N,Z,P,C,V}; both live flags and stack entries use it.
    localparam int FS_W = 5;

    function automatic logic [2:0] derive_nzp(input logic [DATA_W-1:0] r);
        logic n;
        logic z;
        n = r[DATA_W-1];
        z = (r == {DATA_W{1'b0}});
        derive_nzp = {n, z, ~n & ~z};
    endfunction

    logic [FS_W-1:0]  flags_q;
    logic [FS_W-1:0]  flags_d;
    logic [FS_W-1:0]  stack_q [STACK_DEPTH];
    logic [FS_W-1:0]  stack_d [STACK_DEPTH];
    logic [PTR_W-1:0] depth_q;
    logic [PTR_W-1:0] depth_d;
    logic             err_q;
    logic             err_d;

    logic [FS_W-1:0]  top_s;
    logic             empty_s;
    logic             full_s;
    logic             push_req_s;
    logic             do_swap_s;
    logic             do_pop_s;
    logic             do_push_s;
    logic             push_err_s;
    logic             pop_err_s;
    logic             wr_en_s;
    logic [PTR_W-1:0] wr_idx_s;

    // Decode stack occupancy and the per-edge action from pre-edge state.
    always_comb begin
        empty_s    = (depth_q == {PTR_W{1'b0}});
        full_s     = (depth_q == PTR_W'(STACK_DEPTH));
        // push&pop on an empty stack degenerates to a plain push
        push_req_s = push & (~pop | empty_s);
        do_swap_s  = push & pop & ~empty_s;
        do_pop_s   = pop & ~push & ~empty_s;
        do_push_s  = push_req_s & ~full_s;
        push_err_s = push_req_s & full_s;
        pop_err_s  = pop & ~push & empty_s;
    end

    // Read the top-of-stack entry (entry at depth-1).
    always_comb begin
        top_s = {FS_W{1'b0}};
        for (int i = 0; i < STACK_DEPTH; i++) begin
            top_s = (depth_q == PTR_W'(i + 1)) ? stack_q[i] : top_s;
        end
    end

    // Next live flags: a restore from the stack takes priority over we.
    always_comb begin
        if (do_swap_s || do_pop_s) begin
            flags_d = top_s;
        end else if (we) begin
            flags_d = {derive_nzp(result), c_in, v_in};
        end else begin
            flags_d = flags_q;
        end
    end

    // Next occupancy count.
    always_comb begin
        if (do_push_s) begin
            depth_d = depth_q + PTR_W'(1);
        end else if (do_pop_s) begin
            depth_d = depth_q - PTR_W'(1);
        end else begin
            depth_d = depth_q;
        end
    end

    // Stack write: push fills entry[depth], swap overwrites the top entry.
    always_comb begin
        wr_en_s  = do_push_s | do_swap_s;
        wr_idx_s = do_swap_s ? (depth_q - PTR_W'(1)) : depth_q;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            stack_d[i] = (wr_en_s && (wr_idx_s == PTR_W'(i))) ? flags_q : stack_q[i];
        end
    end

    // Sticky error: a new error in the same cycle beats err_clr.
    always_comb begin
        if (push_err_s || pop_err_s) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State registers; reset leaves Z set so exactly one of N/Z/P is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q <= 5'b01000;
            depth_q <= {PTR_W{1'b0}};
            err_q   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= {FS_W{1'b0}};
            end
        end else begin
            flags_q <= flags_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= stack_d[i];
            end
        end
    end

    assign N           = flags_q[4];
    assign Z           = flags_q[3];
    assign P           = flags_q[2];
    assign C           = flags_q[1];
    assign V           = flags_q[0];
    assign br_taken    = |(br_nzp & flags_q[4:2]);
    assign depth       = depth_q;
    assign stack_full  = full_s;
    assign stack_empty = empty_s;
    assign stack_err   = err_q;

endmodule
